scroll_latch_sequencer: RTL and testbench

- Frame-synchronous scroll-register writer for the tile generator subsystem.
- On every vertical-blank start it advances a horizontal and vertical scroll accumulator for each of NUM_LAYERS layers by a per-layer signed step.
- It then replays the new values onto the CUS42/CUS43 latch bus (A, D, nWE, per-layer nLATCH strobes).
- It is the synthesizable, N-layer, H+V generalisation of the hand-written per-frame scroll stimulus. It drives tilegen benches and the FPGA attract-mode demo.

---
 rtl/scroll_latch_sequencer_pkg.sv | 34 +++
 rtl/scroll_latch_sequencer_accum.sv | 28 ++
 rtl/scroll_latch_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_scroll_latch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_latch_sequencer_pkg.sv
// Shared types and constants for the scroll latch sequencer.
package scroll_latch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SETUP,
    STROBE,
    HOLD,
    HALT
  } seq_state_e;

  localparam int unsigned REG_HLO        = 0;
  localparam int unsigned REG_HHI        = 1;
  localparam int unsigned REG_V          = 2;
  localparam int unsigned REGS_PER_LAYER = 3;
  localparam int unsigned REG_IDX_W      = 2;

  // Data byte for one latch register; h arrives zero-extended to 16 bits.
  function automatic logic [7:0] reg_data(input logic [REG_IDX_W-1:0] r,
                                          input logic [15:0] h,
                                          input logic [7:0] v_lo);
    logic [7:0] d;
    d = 8'h00;
    case (r)
      REG_IDX_W'(REG_HLO): d = h[7:0];
      REG_IDX_W'(REG_HHI): d = h[15:8];
      REG_IDX_W'(REG_V):   d = v_lo;
      default:             d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/scroll_latch_sequencer_accum.sv
// One scroll accumulator: modular add of a sign-extended step when upd is high.
module scroll_accum #(
  parameter int unsigned SCROLL_W = 9,
  parameter int unsigned STEP_W   = 4
) (
  input  logic                CLK_6M,
  input  logic                rst_n,
  input  logic                upd,
  input  logic [STEP_W-1:0]   step,
  output logic [SCROLL_W-1:0] acc,
  output logic [SCROLL_W-1:0] sum_c
);

  logic signed [STEP_W-1:0] step_s;

  assign step_s = step;
  // Sized cast of a signed operand sign-extends; the add wraps at SCROLL_W bits.
  assign sum_c  = acc + SCROLL_W'(step_s);

  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (upd) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/scroll_latch_sequencer.sv
// Per-vblank scroll update followed by a replay of every layer's registers onto the latch bus.
module scroll_latch_sequencer
  import scroll_latch_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned SCROLL_W    = 9,
  parameter int unsigned STEP_W      = 4,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned LATCH_PULSE = 2,
  parameter int unsigned MAX_FRAMES  = 0
) (
  input  logic                           CLK_6M,
  input  logic                           rst_n,
  input  logic                           nVBLANK,
  input  logic                           enable,
  input  logic [NUM_LAYERS*STEP_W-1:0]   step_h,
  input  logic [NUM_LAYERS*STEP_W-1:0]   step_v,
  output logic [ADDR_W-1:0]              A,
  output logic [7:0]                     D,
  output logic                           nWE,
  output logic [NUM_LAYERS-1:0]          nLATCH,
  output logic [NUM_LAYERS*SCROLL_W-1:0] hscroll,
  output logic [NUM_LAYERS*SCROLL_W-1:0] vscroll,
  output logic [15:0]                    frame_count,
  output logic                           busy,
  output logic                           overrun,
  output logic                           done
);

  localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CNT_W   = (LATCH_PULSE > 1) ? $clog2(LATCH_PULSE) : 1;

  seq_state_e             state_q, state_d;
  logic [LAYER_W-1:0]     layer_q, layer_d;
  logic [REG_IDX_W-1:0]   reg_q, reg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   vb_prev, vb_start_c, in_seq_c, hit_max_c;
  logic [ADDR_W-1:0]      a_d;
  logic [7:0]             d_d;
  logic                   nwe_d, busy_d, overrun_d, done_d;
  logic [NUM_LAYERS-1:0]  nlatch_d;
  logic [15:0]            fc_d;
  logic [SCROLL_W-1:0]    sel_h_c, sel_v_c;

  logic [SCROLL_W-1:0] h_acc [NUM_LAYERS];
  logic [SCROLL_W-1:0] v_acc [NUM_LAYERS];
  logic [SCROLL_W-1:0] h_sum [NUM_LAYERS];
  logic [SCROLL_W-1:0] v_sum [NUM_LAYERS];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    scroll_accum #(.SCROLL_W(SCROLL_W), .STEP_W(STEP_W)) u_h (
      .CLK_6M (CLK_6M),
      .rst_n  (rst_n),
      .upd    (state_q == UPDATE),
      .step   (step_h[i*STEP_W +: STEP_W]),
      .acc    (h_acc[i]),
      .sum_c  (h_sum[i])
    );
    scroll_accum #(.SCROLL_W(SCROLL_W), .STEP_W(STEP_W)) u_v (
      .CLK_6M (CLK_6M),
      .rst_n  (rst_n),
      .upd    (state_q == UPDATE),
      .step   (step_v[i*STEP_W +: STEP_W]),
      .acc    (v_acc[i]),
      .sum_c  (v_sum[i])
    );
    assign hscroll[i*SCROLL_W +: SCROLL_W] = h_acc[i];
    assign vscroll[i*SCROLL_W +: SCROLL_W] = v_acc[i];
  end

  assign vb_start_c = vb_prev && !nVBLANK;

  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      vb_prev     <= 1'b0;
      A           <= '0;
      D           <= '0;
      nWE         <= 1'b1;
      nLATCH      <= '0;
      frame_count <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      reg_q       <= reg_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      vb_prev     <= nVBLANK;
      A           <= a_d;
      D           <= d_d;
      nWE         <= nwe_d;
      nLATCH      <= nlatch_d;
      frame_count <= fc_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      done        <= done_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    reg_d     = reg_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun;
    fc_d      = frame_count;
    done_d    = done;
    a_d       = A;
    d_d       = D;
    nlatch_d  = '0;
    hit_max_c = 1'b0;
    sel_h_c   = '0;
    sel_v_c   = '0;

    case (state_q)
      IDLE: begin
        if ((vb_start_c || pending_q) && enable && !done) begin
          state_d   = UPDATE;
          pending_d = 1'b0;
        end
      end
      UPDATE: begin
        state_d = SETUP;
        layer_d = '0;
        reg_d   = '0;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(LATCH_PULSE - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (reg_q == REG_IDX_W'(REGS_PER_LAYER - 1)) begin
          if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
            fc_d      = (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;
            hit_max_c = (MAX_FRAMES != 0) && (fc_d == 16'(MAX_FRAMES));
            state_d   = hit_max_c ? HALT : IDLE;
            done_d    = done || hit_max_c;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            reg_d   = '0;
            state_d = SETUP;
          end
        end else begin
          reg_d   = reg_q + REG_IDX_W'(1);
          state_d = SETUP;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A vblank start arriving mid-sequence is queued; a second one is dropped.
    in_seq_c = (state_q == UPDATE) || (state_q == SETUP) ||
               (state_q == STROBE) || (state_q == HOLD);
    if (vb_start_c && in_seq_c) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    busy_d = (state_d == UPDATE) || (state_d == SETUP) ||
             (state_d == STROBE) || (state_d == HOLD);
    nwe_d  = !busy_d;

    // During UPDATE the accumulators have not yet latched, so use the adder outputs.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      nlatch_d[i] = (state_d == STROBE) && (layer_d == LAYER_W'(i));
      if (layer_d == LAYER_W'(i)) begin
        sel_h_c = (state_q == UPDATE) ? h_sum[i] : h_acc[i];
        sel_v_c = (state_q == UPDATE) ? v_sum[i] : v_acc[i];
      end
    end

    if (state_d == SETUP) begin
      a_d = ADDR_W'(reg_d);
      d_d = reg_data(reg_d, 16'(sel_h_c), 8'(sel_v_c));
    end
  end

endmodule

// File: tb/tb_scroll_latch_sequencer.sv
// Directed bench for scroll_latch_sequencer: latch bus traffic, wrap, pending/overrun, reset, frame limit.
module tb_scroll_latch_sequencer;

  localparam int unsigned NL  = 2;
  localparam int unsigned SW  = 9;
  localparam int unsigned STW = 4;
  localparam int unsigned AW  = 13;

  logic CLK_6M = 1'b0;
  logic rst_n = 1'b0;
  logic nVBLANK = 1'b1;
  logic nVBLANK_m = 1'b1;
  logic enable = 1'b0;
  logic [NL*STW-1:0] step_h = '0;
  logic [NL*STW-1:0] step_v = '0;

  logic [AW-1:0] A, A_m;
  logic [7:0] D, D_m;
  logic nWE, nWE_m;
  logic [NL-1:0] nLATCH, nLATCH_m;
  logic [NL*SW-1:0] hscroll, vscroll, hscroll_m, vscroll_m;
  logic [15:0] frame_count, frame_count_m;
  logic busy, busy_m, overrun, overrun_m, done, done_m;

  scroll_latch_sequencer dut (
    .CLK_6M(CLK_6M), .rst_n(rst_n), .nVBLANK(nVBLANK), .enable(enable),
    .step_h(step_h), .step_v(step_v), .A(A), .D(D), .nWE(nWE), .nLATCH(nLATCH),
    .hscroll(hscroll), .vscroll(vscroll), .frame_count(frame_count),
    .busy(busy), .overrun(overrun), .done(done)
  );

  scroll_latch_sequencer #(.MAX_FRAMES(3)) dut_m (
    .CLK_6M(CLK_6M), .rst_n(rst_n), .nVBLANK(nVBLANK_m), .enable(enable),
    .step_h(step_h), .step_v(step_v), .A(A_m), .D(D_m), .nWE(nWE_m), .nLATCH(nLATCH_m),
    .hscroll(hscroll_m), .vscroll(vscroll_m), .frame_count(frame_count_m),
    .busy(busy_m), .overrun(overrun_m), .done(done_m)
  );

  always #5 CLK_6M = ~CLK_6M;

  int checks = 0;
  int errors = 0;

  // Write log of the main DUT: one entry per nLATCH pulse.
  int log_n = 0;
  int busy_cycles = 0;
  int viol = 0;
  int m_strobes = 0;
  logic [AW-1:0] log_a [64];
  logic [7:0]    log_d [64];
  logic [NL-1:0] log_nl [64];
  int            log_len [64];
  logic [NL-1:0] nl_prev = '0;
  logic [NL-1:0] nlm_prev = '0;

  always @(negedge CLK_6M) begin
    if (busy === 1'b1) busy_cycles++;
    if (nWE !== ~busy) viol++;
    if ($countones(nLATCH) > 1 || (nLATCH != 0 && busy !== 1'b1)) viol++;
    if (nLATCH != 0) begin
      if (nl_prev == 0) begin
        if (log_n < 64) begin
          log_a[log_n]   = A;
          log_d[log_n]   = D;
          log_nl[log_n]  = nLATCH;
          log_len[log_n] = 1;
        end
        log_n++;
      end else if (log_n > 0 && log_n <= 64) begin
        log_len[log_n-1]++;
      end
    end
    if (nLATCH_m != 0 && nlm_prev == 0) m_strobes++;
    nl_prev  = nLATCH;
    nlm_prev = nLATCH_m;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_6M);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic edge_vb();
    nVBLANK = 1'b0;
    tick(1);
    nVBLANK = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check(tag, busy, 1'b0);
  endtask

  task automatic frame();
    edge_vb();
    wait_idle("frame_timeout");
  endtask

  task automatic clear_log();
    log_n = 0;
    busy_cycles = 0;
  endtask

  initial begin
    // Reset values, checked while reset is held.
    tick(1);
    check("rst_A", A, 0);
    check("rst_D", D, 0);
    check("rst_nWE", nWE, 1);
    check("rst_nLATCH", nLATCH, 0);
    check("rst_hscroll", hscroll, 0);
    check("rst_vscroll", vscroll, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_flags", {busy, overrun, done}, 3'b000);
    rst_n = 1'b1;
    tick(2);

    // One frame, step_h=+1 on both layers.
    enable = 1'b1;
    step_h = {4'd1, 4'd1};
    clear_log();
    frame();
    check("f1_busy_cycles", busy_cycles, 25);
    check("f1_writes", log_n, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("f1_A%0d", i), log_a[i], i % 3);
      check($sformatf("f1_D%0d", i), log_d[i], (i % 3 == 0) ? 8'h01 : 8'h00);
      check($sformatf("f1_nl%0d", i), log_nl[i], (i < 3) ? 2'b01 : 2'b10);
      check($sformatf("f1_len%0d", i), log_len[i], 2);
    end
    check("f1_frame_count", frame_count, 1);
    check("f1_hscroll", hscroll, {9'd1, 9'd1});

    // With enable low a vblank start is ignored.
    enable = 1'b0;
    edge_vb();
    tick(3);
    check("en0_busy", busy, 0);
    check("en0_frame_count", frame_count, 1);
    enable = 1'b1;

    // Layer-0 H wrap: 511 frames reach 0x1FF, the next wraps to 0.
    do_reset();
    step_h = {4'd0, 4'd1};
    repeat (510) frame();
    clear_log();
    frame();
    check("wrap_h511", hscroll[SW-1:0], 9'h1FF);
    check("wrap_D_lo_FF", log_d[0], 8'hFF);
    check("wrap_D_hi_01", log_d[1], 8'h01);
    clear_log();
    frame();
    check("wrap_h0", hscroll[SW-1:0], 9'h000);
    check("wrap_D_lo_00", log_d[0], 8'h00);
    check("wrap_D_hi_00", log_d[1], 8'h00);
    check("wrap_frame_count", frame_count, 512);

    // Negative V step from reset.
    do_reset();
    step_h = '0;
    step_v = {4'hF, 4'hF};
    clear_log();
    frame();
    check("vneg_vscroll", vscroll, {9'h1FF, 9'h1FF});
    check("vneg_hscroll", hscroll, 0);
    check("vneg_D2", log_d[2], 8'hFF);
    check("vneg_D5", log_d[5], 8'hFF);
    check("vneg_D0", log_d[0], 8'h00);

    // Three edges inside one sequence: one queued, one dropped.
    do_reset();
    step_h = {4'd1, 4'd1};
    step_v = '0;
    clear_log();
    edge_vb();
    tick(4);
    edge_vb();
    tick(4);
    edge_vb();
    wait_idle("ovr_first_timeout");
    check("ovr_fc_after_first", frame_count, 1);
    check("ovr_overrun", overrun, 1);
    tick(1);
    check("ovr_second_started", busy, 1);
    wait_idle("ovr_second_timeout");
    check("ovr_fc_after_second", frame_count, 2);
    tick(30);
    check("ovr_no_third", frame_count, 2);
    check("ovr_busy_cycles", busy_cycles, 50);
    check("ovr_overrun_sticky", overrun, 1);

    // Asynchronous reset during the STROBE of layer 1 register 1.
    do_reset();
    edge_vb();
    begin
      int n;
      n = 0;
      while (!(nLATCH == 2'b10 && A == 1) && n < 60) begin
        tick(1);
        n++;
      end
      if (n >= 60) check("mid_rst_reach_strobe", n, 0);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_A", A, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_nWE", nWE, 1);
    check("mid_rst_nLATCH", nLATCH, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hscroll", hscroll, 0);
    check("mid_rst_fc", frame_count, 0);
    tick(2);
    rst_n = 1'b1;
    clear_log();
    tick(40);
    check("post_rst_no_write", log_n, 0);
    check("post_rst_fc", frame_count, 0);
    frame();
    check("post_rst_frame", frame_count, 1);

    // Frame limit of 3 with five vblank starts.
    m_strobes = 0;
    for (int k = 0; k < 5; k++) begin
      nVBLANK_m = 1'b0;
      tick(1);
      nVBLANK_m = 1'b1;
      tick(30);
      if (k == 1) check("max_done_early", done_m, 0);
      if (k == 2) begin
        check("max_done", done_m, 1);
        check("max_fc3", frame_count_m, 3);
        check("max_strobes3", m_strobes, 18);
      end
    end
    check("max_final_strobes", m_strobes, 18);
    check("max_final_fc", frame_count_m, 3);
    check("max_final_busy", busy_m, 0);
    check("max_final_done", done_m, 1);

    check("bus_invariants", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
